// File: rtl/header_gpio_bank.sv
`default_nettype none
// ============================================================================
// Module   : header_gpio_bank
// Purpose  : Bank of header GPIO pins. Registered push-pull / open-drain pad
//            control, synchronised and debounced inputs, sticky per-pin edge
//            interrupts with write-1-to-clear.
// Revision : 1.0 - initial release
// ============================================================================
module header_gpio_bank #(
  parameter int                 NumPins    = 16,
  parameter int                 SyncStages = 2,
  parameter int                 DebounceW  = 16,
  parameter logic [NumPins-1:0] InResetVal = {NumPins{1'b1}}
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_sys_i,
  input  logic [NumPins-1:0]   pin_i,
  output logic [NumPins-1:0]   pin_o,
  output logic [NumPins-1:0]   pin_oe_o,
  input  logic [NumPins-1:0]   out_val_i,
  input  logic [NumPins-1:0]   out_en_i,
  input  logic [NumPins-1:0]   open_drain_i,
  input  logic [DebounceW-1:0] debounce_limit_i,
  output logic [NumPins-1:0]   in_val_o,
  input  logic [NumPins-1:0]   intr_rise_en_i,
  input  logic [NumPins-1:0]   intr_fall_en_i,
  input  logic [NumPins-1:0]   intr_clear_i,
  output logic [NumPins-1:0]   intr_status_o,
  output logic                 intr_o
);

  localparam logic [DebounceW-1:0] c_one = {{(DebounceW-1){1'b0}}, 1'b1};

  logic [NumPins-1:0]   r_pin;
  logic [NumPins-1:0]   r_pin_oe;
  logic [NumPins-1:0]   r_sync [SyncStages];
  logic [NumPins-1:0]   r_in_val;
  logic [NumPins-1:0]   r_status;
  logic [NumPins-1:0]   w_s;
  logic [NumPins-1:0]   w_upd;
  logic [NumPins-1:0]   w_set;
  logic [DebounceW-1:0] w_lim_m1;

  // Pad drive: open-drain pins only ever pull low, so the enable carries the data.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      r_pin    <= '0;
      r_pin_oe <= '0;
    end else begin
      r_pin    <= out_val_i & ~open_drain_i;
      r_pin_oe <= out_en_i & ~(open_drain_i & out_val_i);
    end
  end

  // Input synchroniser chain; the last stage is the stable sampled value.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      for (int k = 0; k < SyncStages; k++) begin
        r_sync[k] <= InResetVal;
      end
    end else begin
      r_sync[0] <= pin_i;
      for (int k = 1; k < SyncStages; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_s = r_sync[SyncStages-1];

  // A limit of zero behaves as one: the new level must be seen for one cycle.
  always_comb begin
    w_lim_m1 = '0;
    if (debounce_limit_i != '0) begin
      w_lim_m1 = debounce_limit_i - c_one;
    end
  end

  // One debounce counter per pin, producing a single-cycle update strobe.
  for (genvar i = 0; i < NumPins; i++) begin : g_pin
    logic [DebounceW-1:0] r_cnt;

    assign w_upd[i] = (w_s[i] != r_in_val[i]) && (r_cnt >= w_lim_m1);

    // Count mismatch cycles; saturate rather than wrap if the limit is raised late.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
      if (rst_sys_i) begin
        r_cnt <= '0;
      end else if ((w_s[i] == r_in_val[i]) || w_upd[i]) begin
        r_cnt <= '0;
      end else if (r_cnt != {DebounceW{1'b1}}) begin
        r_cnt <= r_cnt + c_one;
      end
    end
  end

  // Debounced value flips exactly on the pins whose update strobe fired.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      r_in_val <= InResetVal;
    end else begin
      r_in_val <= r_in_val ^ w_upd;
    end
  end

  assign w_set = w_upd & ((w_s & intr_rise_en_i) | (~w_s & intr_fall_en_i));

  // Sticky status: clear first, then set, so a coincident event is kept.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      r_status <= '0;
    end else begin
      r_status <= (r_status & ~intr_clear_i) | w_set;
    end
  end

  assign pin_o         = r_pin;
  assign pin_oe_o      = r_pin_oe;
  assign in_val_o      = r_in_val;
  assign intr_status_o = r_status;
  assign intr_o        = |r_status;

endmodule
`default_nettype wire

// File: tb/tb_header_gpio_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_header_gpio_bank
// Purpose  : Self-checking bench for header_gpio_bank: directed scenarios with
//            literal expectations plus randomized traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_header_gpio_bank;

  localparam int NP = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] pin_i, out_val, out_en, od, rise_en, fall_en, clr;
  logic [15:0]   lim;
  logic [NP-1:0] pin_o, pin_oe, in_val, status;
  logic          intr;

  int n_vec = 0;
  int n_err = 0;

  header_gpio_bank #(
    .NumPins(NP), .SyncStages(2), .DebounceW(16), .InResetVal({NP{1'b1}})
  ) dut (
    .clk_sys_i(clk), .rst_sys_i(rst), .pin_i(pin_i), .pin_o(pin_o),
    .pin_oe_o(pin_oe), .out_val_i(out_val), .out_en_i(out_en),
    .open_drain_i(od), .debounce_limit_i(lim), .in_val_o(in_val),
    .intr_rise_en_i(rise_en), .intr_fall_en_i(fall_en),
    .intr_clear_i(clr), .intr_status_o(status), .intr_o(intr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [NP-1:0] m_hist [2];
  logic [NP-1:0] m_in, m_stat, m_po, m_oe;
  logic [NP-1:0] s_old, upd, ev;
  int            m_run [NP];
  int            lim_eff;

  // Model: the sampled pin is the value applied two edges ago; a pin's
  // debounced value follows once it has disagreed for max(L,1) sampled cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hist[0] = '1; m_hist[1] = '1;
      m_in = '1; m_stat = '0; m_po = '0; m_oe = '0;
      for (int p = 0; p < NP; p++) m_run[p] = 0;
    end else begin
      s_old     = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = pin_i;
      lim_eff   = (lim == 0) ? 1 : int'(lim);
      upd       = '0;
      for (int p = 0; p < NP; p++) begin
        if (s_old[p] != m_in[p]) begin
          m_run[p] = m_run[p] + 1;
          if (m_run[p] >= lim_eff) begin
            upd[p]   = 1'b1;
            m_run[p] = 0;
          end
        end else begin
          m_run[p] = 0;
        end
      end
      ev     = upd & ((s_old & rise_en) | (~s_old & fall_en));
      m_stat = (m_stat & ~clr) | ev;
      m_in   = m_in ^ upd;
      for (int p = 0; p < NP; p++) begin
        m_po[p] = od[p] ? 1'b0 : out_val[p];
        m_oe[p] = od[p] ? (out_en[p] && !out_val[p]) : out_en[p];
      end
      #1;
      check("pin_o",  pin_o,  m_po);
      check("pin_oe", pin_oe, m_oe);
      check("in_val", in_val, m_in);
      check("status", status, m_stat);
      check("intr_o", intr,   |m_stat);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; pin_i = '1; out_val = '0; out_en = '0; od = '0;
    rise_en = '0; fall_en = '0; clr = '0; lim = 16'd4;
    #12;
    check("rst_pin_o",  pin_o,  16'h0000);
    check("rst_pin_oe", pin_oe, 16'h0000);
    check("rst_in_val", in_val, 16'hFFFF);
    check("rst_status", status, 16'h0000);
    check("rst_intr",   intr,   1'b0);
    @(negedge clk); rst = 1'b0;
    step(10);

    // Falling edge on pin 0 with L=4: six edges from drive to update.
    fall_en = 16'h0001;
    pin_i[0] = 1'b0;
    step(5);
    check("fall_pre_in0", in_val[0], 1'b1);
    check("fall_pre_st0", status[0], 1'b0);
    step(1);
    check("fall_in0",   in_val[0], 1'b0);
    check("fall_st0",   status[0], 1'b1);
    check("fall_intr",  intr,      1'b1);
    pin_i[0] = 1'b1;
    step(10);
    clr = '1; step(1); clr = '0;
    check("clear_all", status, 16'h0000);

    // Short low glitch on pin 3 is filtered.
    fall_en = 16'h0008;
    pin_i[3] = 1'b0; step(3); pin_i[3] = 1'b1;
    step(10);
    check("glitch_in3", in_val[3], 1'b1);
    check("glitch_st3", status[3], 1'b0);

    // Bypass debounce on pin 5, clear coincident with the second event.
    lim = 16'd0; fall_en = '0;
    pin_i[5] = 1'b0; step(6);
    clr = '1; step(1); clr = '0;
    rise_en = 16'h0020; fall_en = 16'h0020;
    pin_i[5] = 1'b1;
    step(2);
    check("byp_pre_in5", in_val[5], 1'b0);
    step(1);
    check("byp_rise_in5", in_val[5], 1'b1);
    check("byp_rise_st5", status[5], 1'b1);
    step(1);
    pin_i[5] = 1'b0;
    step(2);
    clr = 16'h0020;
    step(1);
    clr = '0;
    check("byp_fall_in5", in_val[5], 1'b0);
    check("byp_set_wins", status[5], 1'b1);
    step(4);

    // Open-drain then push-pull on pin 2.
    od = 16'h0004; out_en = 16'h0004; out_val = 16'h0000;
    step(1);
    check("od_lo_oe2", pin_oe[2], 1'b1);
    check("od_lo_po2", pin_o[2],  1'b0);
    out_val = 16'h0004;
    step(1);
    check("od_hi_oe2", pin_oe[2], 1'b0);
    check("od_hi_po2", pin_o[2],  1'b0);
    od = 16'h0000;
    step(1);
    check("pp_oe2", pin_oe[2], 1'b1);
    check("pp_po2", pin_o[2],  1'b1);

    // Fill status, then reset asynchronously mid-count.
    lim = 16'd1; rise_en = '1; fall_en = '1;
    pin_i = '0; step(6);
    pin_i = '1; step(6);
    check("all_status", status, 16'hFFFF);
    lim = 16'd4; pin_i = '0;
    step(3);
    #1 rst = 1'b1;
    #1;
    check("arst_pin_o",  pin_o,  16'h0000);
    check("arst_pin_oe", pin_oe, 16'h0000);
    check("arst_in_val", in_val, 16'hFFFF);
    check("arst_status", status, 16'h0000);
    check("arst_intr",   intr,   1'b0);
    pin_i = '1;
    step(2);
    rst = 1'b0;
    step(10);
    check("post_rst_status", status, 16'h0000);
    check("post_rst_in_val", in_val, 16'hFFFF);

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) pin_i = pin_i ^ (16'h1 << $urandom_range(0, NP-1));
      out_val = 16'($urandom);
      out_en  = 16'($urandom);
      od      = 16'($urandom);
      if ($urandom_range(0, 15) == 0) lim = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 31) == 0) begin
        rise_en = 16'($urandom);
        fall_en = 16'($urandom);
      end
      clr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0000;
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
